// File: rtl/nes_palette_loader.sv
// rtl/nes_palette_loader.sv - byte-stream palette file loader for the video palette write port
// Packs R,G,B download bytes into 24-bit entries and strobes them into palette RAM in host-permitted cycles.
module nes_palette_loader #(
  parameter int ENTRIES   = 64,
  parameter int IDX_W     = 6,
  parameter bit BGR_ORDER = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dl_start_i,
  input  logic [7:0]       dl_byte_i,
  input  logic             dl_valid_i,
  output logic             dl_ready_o,
  input  logic             dl_end_i,
  input  logic             wr_allow_i,
  output logic             load_color_o,
  output logic [IDX_W-1:0] load_color_index_o,
  output logic [23:0]      load_color_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [IDX_W:0]   entries_written_o
);

  localparam logic [IDX_W:0] ENTRIES_C = (IDX_W+1)'(ENTRIES);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_idx_q, last_idx_d;
  logic [IDX_W:0]   cnt_q, cnt_d;
  logic [7:0]       byte0_q, byte0_d, byte1_q, byte1_d;
  logic [23:0]      pend_q, pend_d, last_data_q, last_data_d;
  logic             done_q, done_d, error_q, error_d;
  logic             ovf_q, ovf_d, end_q, end_d;
  logic             hs, strobe, full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      phase_q     <= 2'd0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      cnt_q       <= '0;
      byte0_q     <= 8'd0;
      byte1_q     <= 8'd0;
      pend_q      <= 24'd0;
      last_data_q <= 24'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ovf_q       <= 1'b0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      idx_q       <= idx_d;
      last_idx_q  <= last_idx_d;
      cnt_q       <= cnt_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      pend_q      <= pend_d;
      last_data_q <= last_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
      ovf_q       <= ovf_d;
      end_q       <= end_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    idx_d       = idx_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    pend_d      = pend_q;
    last_data_d = last_data_q;
    done_d      = done_q;
    error_d     = error_q;
    ovf_d       = ovf_q;
    end_d       = end_q;

    // A restart or reset in the same cycle cancels any handshake or strobe.
    dl_ready_o = (state_q == COLLECT) && !reset && !dl_start_i;
    hs         = dl_ready_o && dl_valid_i;
    strobe     = (state_q == WRITE) && wr_allow_i && !reset && !dl_start_i;
    full       = (cnt_q >= ENTRIES_C);

    if (dl_start_i) begin
      state_d = COLLECT;
      phase_d = 2'd0;
      idx_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
      ovf_d   = 1'b0;
      end_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        COLLECT: begin
          if (hs) begin
            if (full) begin
              ovf_d   = 1'b1;
              error_d = 1'b1;
            end else begin
              case (phase_q)
                2'd0: begin
                  byte0_d = dl_byte_i;
                  phase_d = 2'd1;
                end
                2'd1: begin
                  byte1_d = dl_byte_i;
                  phase_d = 2'd2;
                end
                default: begin
                  pend_d  = BGR_ORDER ? {dl_byte_i, byte1_q, byte0_q}
                                      : {byte0_q, byte1_q, dl_byte_i};
                  phase_d = 2'd0;
                  state_d = WRITE;
                end
              endcase
            end
          end
          if (dl_end_i) begin
            if (state_d == WRITE) end_d = 1'b1;
            else                  state_d = FINISH;
          end
        end
        WRITE: begin
          if (dl_end_i) end_d = 1'b1;
          if (strobe) begin
            idx_d       = idx_q + IDX_W'(1);
            cnt_d       = cnt_q + (IDX_W+1)'(1);
            last_idx_d  = idx_q;
            last_data_d = pend_q;
            end_d       = 1'b0;
            state_d     = (end_q || dl_end_i) ? FINISH : COLLECT;
          end
        end
        FINISH: begin
          if (cnt_q == ENTRIES_C && phase_q == 2'd0 && !ovf_q) done_d = 1'b1;
          else                                                 error_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Index and data only change on the strobe, so the RAM port never sees a half-updated entry.
  assign load_color_o       = strobe;
  assign load_color_index_o = strobe ? idx_q  : last_idx_q;
  assign load_color_data_o  = strobe ? pend_q : last_data_q;
  assign busy_o             = ((state_q == COLLECT) || (state_q == WRITE)) && !reset;
  assign done_o             = done_q;
  assign error_o            = error_q;
  assign entries_written_o  = cnt_q;

endmodule

// File: tb/tb_nes_palette_loader.sv
// tb/tb_nes_palette_loader.sv - self-checking bench for nes_palette_loader
// Table of whole-file cases plus hand sequences for restart, BGR packing and reset during a pending write.
module tb_nes_palette_loader;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;

  logic             clk = 1'b0;
  logic             reset, dl_start, dl_valid, dl_end, wr_allow;
  logic [7:0]       dl_byte;
  logic             dl_ready, load_color, busy, done, error;
  logic [IDX_W-1:0] load_color_index;
  logic [23:0]      load_color_data;
  logic [IDX_W:0]   entries_written;
  logic             b_ready, b_load, b_busy, b_done, b_error;
  logic [IDX_W-1:0] b_index;
  logic [23:0]      b_data;
  logic [IDX_W:0]   b_written;

  nes_palette_loader #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .BGR_ORDER(1'b0)) u_dut (
    .clk(clk), .reset(reset), .dl_start_i(dl_start), .dl_byte_i(dl_byte),
    .dl_valid_i(dl_valid), .dl_ready_o(dl_ready), .dl_end_i(dl_end), .wr_allow_i(wr_allow),
    .load_color_o(load_color), .load_color_index_o(load_color_index),
    .load_color_data_o(load_color_data), .busy_o(busy), .done_o(done), .error_o(error),
    .entries_written_o(entries_written));

  nes_palette_loader #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .BGR_ORDER(1'b1)) u_bgr (
    .clk(clk), .reset(reset), .dl_start_i(dl_start), .dl_byte_i(dl_byte),
    .dl_valid_i(dl_valid), .dl_ready_o(b_ready), .dl_end_i(dl_end), .wr_allow_i(wr_allow),
    .load_color_o(b_load), .load_color_index_o(b_index),
    .load_color_data_o(b_data), .busy_o(b_busy), .done_o(b_done), .error_o(b_error),
    .entries_written_o(b_written));

  typedef struct packed {logic [IDX_W-1:0] idx; logic [23:0] data;} exp_t;
  typedef struct {int nbytes; int wr_mode; int strobes; int done; int err; int written;} vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  int          model_cnt, byte_pos, strobe_cnt, wr_mode;
  bit          pending, prev_strobe, wr_force;
  logic [7:0]  bytes3[3];
  logic [23:0] ram[ENTRIES];
  logic [23:0] bgr_data;

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got still running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int k);
    logic [7:0] n;
    n = 8'(k / 3);
    case (k % 3)
      0:       return n;
      1:       return n ^ 8'hFF;
      default: return 8'h5A;
    endcase
  endfunction

  // Expected writes are derived from the bytes seen crossing the handshake.
  task automatic monitor_step();
    exp_t e;
    if (reset || dl_start) begin
      exp_q.delete();
      model_cnt = 0;
      byte_pos  = 0;
      pending   = 1'b0;
      if (dl_start) strobe_cnt = 0;
    end else begin
      if (pending) chk("ready_low_while_pending", 32'(dl_ready), 0);
      if (load_color) begin
        chk("strobe_only_when_allowed", 32'(wr_allow), 1);
        chk("no_back_to_back_strobe", 32'(prev_strobe), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got index %0d data 0x%06h, expected no write",
                   load_color_index, load_color_data);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_index", 32'(load_color_index), 32'(e.idx));
          chk("strobe_data", 32'(load_color_data), 32'(e.data));
        end
        ram[load_color_index] = load_color_data;
        strobe_cnt++;
        pending = 1'b0;
      end
      if (dl_valid && dl_ready && model_cnt < ENTRIES) begin
        bytes3[byte_pos] = dl_byte;
        if (byte_pos == 2) begin
          e.idx  = IDX_W'(model_cnt);
          e.data = {bytes3[0], bytes3[1], bytes3[2]};
          exp_q.push_back(e);
          model_cnt++;
          byte_pos = 0;
          pending  = 1'b1;
        end else begin
          byte_pos++;
        end
      end
    end
    if (b_load) bgr_data = b_data;
    prev_strobe = load_color && !reset;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit nostall);
    int n = 0;
    dl_byte  = b;
    dl_valid = 1'b1;
    @(negedge clk);
    while (!dl_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("byte_accepted", 32'(dl_ready), 1);
    if (nostall) chk("overflow_no_stall", n, 0);
    @(posedge clk);
    #1 dl_valid = 1'b0;
  endtask

  task automatic pulse_start();
    dl_start = 1'b1;
    @(posedge clk);
    #1 dl_start = 1'b0;
  endtask

  task automatic pulse_end();
    dl_end = 1'b1;
    @(posedge clk);
    #1 dl_end = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("load_finishes", 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_dl_ready", 32'(dl_ready), 0);
    chk("rst_load_color", 32'(load_color), 0);
    chk("rst_index", 32'(load_color_index), 0);
    chk("rst_data", 32'(load_color_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_entries_written", 32'(entries_written), 0);
  endtask

  task automatic run_file(input int nbytes, input int mode, input int exp_strobes,
                          input int exp_done, input int exp_err, input int exp_written);
    wr_mode = mode;
    ram[10] = 24'd0;
    @(posedge clk);
    #1 pulse_start();
    for (int k = 0; k < nbytes; k++) send_byte(gen_byte(k), k > 3 * ENTRIES);
    pulse_end();
    wait_idle();
    chk("strobe_count", strobe_cnt, exp_strobes);
    chk("done", 32'(done), exp_done);
    chk("error", 32'(error), exp_err);
    chk("entries_written", 32'(entries_written), exp_written);
    chk("queue_drained", exp_q.size(), 0);
    if (nbytes == 3 * ENTRIES) chk("ram_entry10", 32'(ram[10]), 32'h0A_F55A);
  endtask

  initial begin
    vecs[0] = '{192, 0, 64, 1, 0, 64};
    vecs[1] = '{192, 1, 64, 1, 0, 64};
    vecs[2] = '{190, 0, 63, 0, 1, 63};
    vecs[3] = '{195, 0, 64, 0, 1, 64};
    vecs[4] = '{3,   0, 1,  0, 1, 1};
    vecs[5] = '{0,   1, 0,  0, 1, 0};

    reset    = 1'b1;
    dl_start = 1'b0;
    dl_valid = 1'b0;
    dl_end   = 1'b0;
    dl_byte  = 8'd0;
    wr_allow = 1'b0;
    wr_mode  = 0;
    wr_force = 1'b0;
    bgr_data = 24'd0;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
      begin : wr_drive
        int cyc = 0;
        forever begin
          @(posedge clk);
          #1 cyc++;
          case (wr_mode)
            0:       wr_allow = 1'b1;
            1:       wr_allow = (cyc % 4 == 0);
            default: wr_allow = wr_force;
          endcase
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    for (int i = 0; i < 6; i++)
      run_file(vecs[i].nbytes, vecs[i].wr_mode, vecs[i].strobes,
               vecs[i].done, vecs[i].err, vecs[i].written);

    // Restart mid-file with a partial triplet outstanding.
    wr_mode = 0;
    @(posedge clk);
    #1 pulse_start();
    for (int k = 0; k < 91; k++) send_byte(gen_byte(k), 1'b0);
    chk("entries_before_restart", 32'(entries_written), 30);
    run_file(192, 0, 64, 1, 0, 64);

    @(posedge clk);
    #1 pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    pulse_end();
    wait_idle();
    chk("bgr_packing", 32'(bgr_data), 32'h33_2211);
    chk("one_entry_file_error", 32'(error), 1);

    // Reset lands while a write is held off by wr_allow.
    wr_mode  = 2;
    wr_force = 1'b0;
    @(posedge clk);
    #1 pulse_start();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    @(negedge clk);
    chk("write_held_off", 32'(load_color), 0);
    chk("busy_during_write", 32'(busy), 1);
    chk("data_holds_while_pending", 32'(load_color_data), 32'h11_2233);
    wr_force = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("no_strobe_in_reset", 32'(load_color), 0);
    chk("bgr_no_strobe_in_reset", 32'(b_load), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (4) @(negedge clk);
    chk("no_strobe_after_reset", 32'(load_color), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
